// File: rtl/tribus_arbiter.sv
// Round-robin arbiter for N requesters sharing one tri-state bus.
// Grants are bounded by MAXHOLD cycles, and TURN dead cycles separate two owners.
module tribus_arbiter #(
  parameter int N       = 4,
  parameter int TURN    = 1,
  parameter int MAXHOLD = 16
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         oe,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 timeout
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [2:0]      tcnt_q, tcnt_d;
  logic            timeout_q, timeout_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic            rel_vol;
  logic            rel_exp;

  // Round-robin search starting one past the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 1; i <= N; i++) begin
      if (!win_found && req[(int'(ptr_q) + i) % N]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(ptr_q) + i) % N);
      end
    end
  end

  assign rel_vol = done[owner_q] | ~req[owner_q];
  assign rel_exp = (cnt_q == 8'(MAXHOLD - 1));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    timeout_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d          = ST_OWN;
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          owner_d          = win_idx;
          ptr_d            = win_idx;
          cnt_d            = '0;
        end
      end
      ST_OWN: begin
        cnt_d = cnt_q + 8'd1;
        if (rel_vol || rel_exp) begin
          state_d   = ST_TURN;
          gnt_d     = '0;
          tcnt_d    = '0;
          // A voluntary release on the expiry edge is not a timeout.
          timeout_d = rel_exp && !rel_vol;
        end
      end
      ST_TURN: begin
        if (tcnt_q == 3'(TURN - 1)) begin
          if (win_found) begin
            state_d          = ST_OWN;
            gnt_d            = '0;
            gnt_d[win_idx]   = 1'b1;
            owner_d          = win_idx;
            ptr_d            = win_idx;
            cnt_d            = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tcnt_d = tcnt_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Pointer resets to N-1 so the first search after reset starts at requester 0.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= IW'(N - 1);
      cnt_q     <= '0;
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign oe      = gnt_q;
  assign owner   = owner_q;
  assign busy    = (state_q == ST_OWN);
  assign timeout = timeout_q;

endmodule

// File: doc/tribus_arbiter.md
TRIBUS_ARBITER -- requirements
Module: tribus_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, number of requesters sharing one tri-state bus (2..8).
REQ-002 The block SHALL have parameter TURN, default 1, number of bus-turnaround cycles with no driver enabled (1..7).
REQ-003 The block SHALL have parameter MAXHOLD, default 16, maximum ownership cycles per grant (2..255).
REQ-004 The block SHALL have port clk, input, 1 bit, clock; all state changes on its rising edge.
REQ-005 The block SHALL have port clr, input, 1 bit, reset, asynchronous, active-low.
REQ-006 The block SHALL have port req, input, N bits, per-requester bus request, level.
REQ-007 The block SHALL have port done, input, N bits, per-requester release pulse.
REQ-008 The block SHALL have port gnt, output, N bits, one-hot-or-zero grant, registered.
REQ-009 The block SHALL have port oe, output, N bits, driver enables for the requesters' bufif1 drivers, registered.
REQ-010 The block SHALL have port owner, output, clog2(N) bits, index of the current or last owner.
REQ-011 The block SHALL have port busy, output, 1 bit, high while a grant is active.
REQ-012 The block SHALL have port timeout, output, 1 bit, one-cycle pulse on forced release.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, OWN and TURN.
REQ-014 In IDLE with req!=0 at an edge, the block SHALL grant the winner at that edge: gnt/oe one-hot, busy=1, owner=index, state=OWN, one-cycle latency from req.
REQ-015 Arbitration SHALL be round-robin: search starts at pointer+1 mod N, and the pointer is set to the winner on each grant.
REQ-016 In OWN, the hold counter SHALL start at 0 on grant and increment each cycle.
REQ-017 The grant SHALL be released at the edge where done[owner]=1, req[owner]=0 or the counter equals MAXHOLD-1, whichever occurs first.
REQ-018 On release, gnt, oe and busy SHALL go to 0 at that edge and state SHALL become TURN.
REQ-019 A counter-expiry release SHALL pulse timeout for exactly one cycle, coincident with the first TURN cycle.
REQ-020 If done/req and counter expiry occur on the same edge, timeout SHALL remain 0 (the release counts as voluntary).
REQ-021 done bits of non-owners SHALL be ignored in every state; done in IDLE or TURN SHALL have no effect.
REQ-022 The block SHALL stay in TURN for exactly TURN cycles with oe=0.
REQ-023 On the last TURN cycle the block SHALL arbitrate as in IDLE, so a pending req is granted with no extra idle cycle; if req=0 the next state SHALL be IDLE.
REQ-024 Bus dead time between two owners SHALL be exactly TURN cycles.
REQ-025 Minimum ownership SHALL be 1 cycle, even if req drops in the cycle after grant.
REQ-026 oe SHALL equal gnt at all times, SHALL have at most one bit set, and SHALL be 0 in IDLE and TURN.
REQ-027 owner SHALL hold its value after release until the next grant.

Reset
REQ-028 When clr=0, the block SHALL asynchronously force gnt=0, oe=0, busy=0, timeout=0, owner=0, counter=0, pointer=N-1 and state=IDLE.
REQ-029 A clr assertion during OWN SHALL drop oe in the same cycle, with no clock required.
REQ-030 After clr rises, the first arbitration SHALL favour requester 0.

Verification
REQ-031 Bench SHALL cover: reset, then req=0100 at edge 0 -> gnt=oe=0100, owner=2, busy=1 after edge 0; done[2] at edge 3 -> gnt=0 after edge 3, one TURN cycle, then IDLE.
REQ-032 Bench SHALL cover: req=1111 held, each owner pulses done on its 2nd cycle -> grant order 0,1,2,3,0, with exactly one oe=0000 cycle between owners.
REQ-033 Bench SHALL cover: req=0010 held, no done -> gnt=0010 for 16 cycles, timeout pulse, one TURN cycle, then regrant to 1; repeat with req=1010 -> next grant goes to 3.
REQ-034 Bench SHALL cover: clr low mid-OWN with gnt=0100 -> gnt=oe=0 immediately; after release with req=1111 -> gnt=0001.
REQ-035 Bench SHALL cover: done=1000 while owner=0 -> no release; req[0] drops -> release at that edge, timeout=0.
REQ-036 Bench SHALL cover: a continuous assertion for all runs that oe is one-hot-or-zero, oe==gnt, and oe=0 in TURN.
